// File: rtl/operand_fetch_module_if.sv
// operand_fetch_module_if: DOF-stage inputs, write-back port and EX-facing outputs
interface operand_fetch_module_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int PCW = 16,
  parameter int CNTW = 16
);
  logic VALID_IN;
  logic [PCW-1:0] PC_1;
  logic [AW-1:0] SA, SB;
  logic [14:0] IMM;
  logic MA, MB, CS;
  logic [21:0] CW_IN;
  logic FLUSH;
  logic RW_WB;
  logic [AW-1:0] DA_WB;
  logic [DW-1:0] BUS_D;
  logic STALL;
  logic [PCW-1:0] PC_2;
  logic [DW-1:0] A, B;
  logic RW, MW, PS;
  logic [1:0] MD, BS;
  logic [4:0] FS, SH, DA;
  logic [CNTW-1:0] STALL_CNT;
  modport master (
    output VALID_IN, PC_1, SA, SB, IMM, MA, MB, CS, CW_IN, FLUSH, RW_WB, DA_WB, BUS_D,
    input STALL, PC_2, A, B, RW, MW, PS, MD, BS, FS, SH, DA, STALL_CNT
  );
  modport slave (
    input VALID_IN, PC_1, SA, SB, IMM, MA, MB, CS, CW_IN, FLUSH, RW_WB, DA_WB, BUS_D,
    output STALL, PC_2, A, B, RW, MW, PS, MD, BS, FS, SH, DA, STALL_CNT
  );
endinterface

// File: rtl/operand_fetch_module.sv
// operand_fetch_module: register file, operand muxing, RAW stall and DOF/EX pipeline register
module operand_fetch_module #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int PCW = 16,
  parameter int CNTW = 16
) (
  input logic CLK,
  input logic reset,
  operand_fetch_module_if.slave bus
);
  logic [DW-1:0] rf [0:(2**AW)-1];
  logic wb_en, load, haz;
  logic [DW-1:0] reg_a, reg_b, op_a, op_b;
  assign wb_en = bus.RW_WB & (bus.DA_WB != '0);
  always_ff @(posedge CLK)
    if (wb_en) rf[bus.DA_WB] <= bus.BUS_D;
  // write-through bypass lets WB and DOF touch the same register in one cycle
  always_comb begin
    reg_a = (bus.SA == '0) ? '0 : (wb_en && bus.DA_WB == bus.SA) ? bus.BUS_D : rf[bus.SA];
    reg_b = (bus.SB == '0) ? '0 : (wb_en && bus.DA_WB == bus.SB) ? bus.BUS_D : rf[bus.SB];
    op_a = bus.MA ? {{(DW-PCW){1'b0}}, bus.PC_1} : reg_a;
    op_b = bus.MB ? {{(DW-15){bus.CS & bus.IMM[14]}}, bus.IMM} : reg_b;
  end
  assign haz = bus.VALID_IN & bus.RW & (bus.DA != '0) &
               ((~bus.MA & (bus.SA == bus.DA)) | (~bus.MB & (bus.SB == bus.DA)));
  assign bus.STALL = haz & ~bus.FLUSH;
  assign load = bus.VALID_IN & ~bus.FLUSH & ~bus.STALL;
  always_ff @(posedge CLK) begin
    if (reset || !load) begin
      bus.PC_2 <= '0;
      bus.A <= '0;
      bus.B <= '0;
      {bus.RW, bus.MD, bus.BS, bus.PS, bus.MW, bus.FS, bus.SH, bus.DA} <= '0;
    end else begin
      bus.PC_2 <= bus.PC_1;
      bus.A <= op_a;
      bus.B <= op_b;
      {bus.RW, bus.MD, bus.BS, bus.PS, bus.MW, bus.FS, bus.SH, bus.DA} <= bus.CW_IN;
    end
  end
  always_ff @(posedge CLK)
    if (reset) bus.STALL_CNT <= '0;
    else if (bus.STALL && !(&bus.STALL_CNT)) bus.STALL_CNT <= bus.STALL_CNT + 1'b1;
endmodule

// File: tb/tb_operand_fetch_module.sv
// tb_operand_fetch_module: directed vectors with hand-computed expectations
module tb_operand_fetch_module;
  logic CLK = 0;
  logic reset = 1;
  int n_cmp = 0;
  int n_bad = 0;
  operand_fetch_module_if bus ();
  operand_fetch_module dut (.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  function automatic logic [21:0] cw(input logic rw, input logic [4:0] fs, input logic [4:0] da);
    return {rw, 2'b00, 2'b00, 1'b0, 1'b0, fs, 5'd0, da};
  endfunction
  initial begin
    {bus.VALID_IN, bus.PC_1, bus.SA, bus.SB, bus.IMM, bus.MA, bus.MB, bus.CS} = '0;
    {bus.CW_IN, bus.FLUSH, bus.RW_WB, bus.DA_WB, bus.BUS_D} = '0;
    step();
    step();
    reset = 0;
    repeat (3) step();
    chk("rst_A", bus.A, 0);
    chk("rst_B", bus.B, 0);
    chk("rst_RW", 32'(bus.RW), 0);
    chk("rst_DA", 32'(bus.DA), 0);
    chk("rst_PC2", 32'(bus.PC_2), 0);
    chk("rst_STALL", 32'(bus.STALL), 0);
    chk("rst_CNT", 32'(bus.STALL_CNT), 0);
    bus.RW_WB = 1; bus.DA_WB = 9; bus.BUS_D = 5;
    step();
    bus.DA_WB = 10; bus.BUS_D = 19;
    step();
    bus.RW_WB = 0;
    bus.VALID_IN = 1; bus.SA = 9; bus.SB = 10; bus.PC_1 = 16'h0042;
    bus.CW_IN = {1'b1, 2'b01, 2'b10, 1'b1, 1'b1, 5'b00010, 5'd3, 5'd11};
    #1 chk("add_nostall", 32'(bus.STALL), 0);
    step();
    chk("add_A", bus.A, 5);
    chk("add_B", bus.B, 19);
    chk("add_RW", 32'(bus.RW), 1);
    chk("add_DA", 32'(bus.DA), 11);
    chk("add_FS", 32'(bus.FS), 2);
    chk("add_SH", 32'(bus.SH), 3);
    chk("add_MDBS", 32'({bus.MD, bus.BS}), 32'b0110);
    chk("add_PSMW", 32'({bus.PS, bus.MW}), 32'b11);
    chk("add_PC2", 32'(bus.PC_2), 32'h42);
    bus.SA = 3; bus.RW_WB = 1; bus.DA_WB = 3; bus.BUS_D = 32'hAA; bus.CW_IN = cw(1, 5'd2, 5'd12);
    step();
    chk("byp_A", bus.A, 32'hAA);
    chk("byp_B", bus.B, 19);
    bus.SA = 0; bus.SB = 0; bus.DA_WB = 0; bus.BUS_D = 32'h55; bus.CW_IN = cw(0, 5'd0, 5'd0);
    step();
    chk("r0_byp_A", bus.A, 0);
    bus.RW_WB = 0;
    step();
    chk("r0_A", bus.A, 0);
    chk("r0_B", bus.B, 0);
    bus.MA = 1; bus.MB = 1; bus.PC_1 = 16'h0010; bus.IMM = 15'h7FFA; bus.CS = 1;
    step();
    chk("imm_sx_B", bus.B, 32'hFFFFFFFA);
    chk("pc_A", bus.A, 32'h10);
    bus.CS = 0;
    step();
    chk("imm_zx_B", bus.B, 32'h00007FFA);
    bus.MA = 0; bus.MB = 0; bus.SA = 9; bus.SB = 10; bus.CW_IN = cw(1, 5'd2, 5'd11);
    step();
    chk("prod_DA", 32'(bus.DA), 11);
    bus.SA = 11; bus.MB = 1; bus.IMM = 15'd1; bus.CW_IN = cw(1, 5'd2, 5'd13);
    #1 chk("raw_STALL", 32'(bus.STALL), 1);
    step();
    chk("raw_bub_RW", 32'(bus.RW), 0);
    chk("raw_bub_DA", 32'(bus.DA), 0);
    chk("raw_bub_A", bus.A, 0);
    chk("raw_bub_MDMW", 32'({bus.MD, bus.MW, bus.PS}), 0);
    chk("raw_CNT", 32'(bus.STALL_CNT), 1);
    bus.RW_WB = 1; bus.DA_WB = 11; bus.BUS_D = 32'h24;
    #1 chk("raw_unstall", 32'(bus.STALL), 0);
    step();
    chk("raw_A", bus.A, 32'h24);
    chk("raw_B", bus.B, 1);
    chk("raw_DA", 32'(bus.DA), 13);
    chk("raw_CNT2", 32'(bus.STALL_CNT), 1);
    bus.RW_WB = 0; bus.SA = 13; bus.FLUSH = 1; bus.CW_IN = cw(1, 5'd2, 5'd14);
    #1 chk("fl_STALL", 32'(bus.STALL), 0);
    step();
    chk("fl_RW", 32'(bus.RW), 0);
    chk("fl_DA", 32'(bus.DA), 0);
    chk("fl_A", bus.A, 0);
    chk("fl_CNT", 32'(bus.STALL_CNT), 1);
    bus.FLUSH = 0; bus.SA = 9; bus.CW_IN = cw(1, 5'd2, 5'd15);
    step();
    chk("pre_rst_DA", 32'(bus.DA), 15);
    bus.SA = 15; bus.CW_IN = cw(1, 5'd2, 5'd16);
    #1 chk("rst_stall_STALL", 32'(bus.STALL), 1);
    reset = 1;
    step();
    reset = 0;
    bus.VALID_IN = 0;
    chk("mid_rst_A", bus.A, 0);
    chk("mid_rst_RW", 32'(bus.RW), 0);
    chk("mid_rst_DA", 32'(bus.DA), 0);
    chk("mid_rst_CNT", 32'(bus.STALL_CNT), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
